// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte-lane aligned loads/stores over a req/gnt/rvalid
// port, upstream stall while an access is outstanding, and registered writeback.

module mem_stage_lane (
   input  logic [7:0] din,
   input  logic       keep,
   input  logic       fill,
   output logic [7:0] dout
);
   assign dout = keep ? din : {8{fill}};
endmodule

module mem_stage #(
   parameter int          DATA_W  = 64,
   parameter logic [63:0] RST_PC4 = '0
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              in_valid,
   input  logic              in_is_write_dmem,
   input  logic [1:0]        in_wb_select,
   input  logic [7:0]        in_write_width,
   input  logic              in_load_unsigned,
   input  logic [DATA_W-1:0] in_rs2_data,
   input  logic [DATA_W-1:0] in_alu_res,
   input  logic [DATA_W-1:0] in_pc_plus_4,
   input  logic [4:0]        in_rd,
   output logic              mem_stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [7:0]        dmem_wstrb,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              wb_valid,
   output logic              wb_reg_we,
   output logic [4:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              misalign
);
   localparam int NUM_LANES = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   // Access context kept for load formatting and writeback while the bus is busy.
   typedef struct packed {
      logic [2:0] off;
      logic [7:0] width;
      logic       uns;
      logic [4:0] rd;
   } acc_t;

   state_t            state;
   acc_t              acc_q;
   logic              access, legal, misaligned;
   logic [2:0]        off;
   logic [8:0]        mask9;
   logic [DATA_W-1:0] ld_shift, ld_fmt;
   logic              ld_top, ld_fill;
   logic              unused_rsvd;

   assign unused_rsvd = |RST_PC4;

   assign access     = in_valid & (in_is_write_dmem | (in_wb_select == 2'b01));
   assign off        = in_alu_res[2:0];
   assign mask9      = {1'b0, in_write_width} << off;
   assign legal      = (in_write_width == 8'h01) || (in_write_width == 8'h03) ||
                       (in_write_width == 8'h0F) || (in_write_width == 8'hFF);
   assign misaligned = mask9[8] | ~legal;

   always_comb begin
      mem_stall = 1'b0;
      case (state)
         IDLE:    mem_stall = access & ~misaligned;
         REQ:     mem_stall = ~(dmem_we & dmem_gnt);
         RESP:    mem_stall = ~dmem_rvalid;
         default: mem_stall = 1'b0;
      endcase
   end

   // Sign source is the top bit of the highest byte covered by the access width.
   assign ld_shift = dmem_rdata >> {acc_q.off, 3'b000};
   always_comb begin
      case (acc_q.width)
         8'h01:   ld_top = ld_shift[7];
         8'h03:   ld_top = ld_shift[15];
         8'h0F:   ld_top = ld_shift[31];
         default: ld_top = ld_shift[DATA_W-1];
      endcase
   end
   assign ld_fill = ld_top & ~acc_q.uns;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      mem_stage_lane u_lane (
         .din  (ld_shift[8*i +: 8]),
         .keep (acc_q.width[i]),
         .fill (ld_fill),
         .dout (ld_fmt[8*i +: 8])
      );
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= IDLE;
         acc_q      <= '0;
         wb_valid   <= 1'b0;
         wb_reg_we  <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
         misalign   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_wstrb <= '0;
      end else begin
         wb_valid <= 1'b0;
         misalign <= 1'b0;
         case (state)
            IDLE: if (in_valid) begin
               if (access && misaligned) begin
                  wb_valid  <= 1'b1;
                  wb_reg_we <= 1'b0;
                  wb_rd     <= in_rd;
                  misalign  <= 1'b1;
               end else if (access) begin
                  state      <= REQ;
                  dmem_req   <= 1'b1;
                  dmem_we    <= in_is_write_dmem;
                  dmem_addr  <= {in_alu_res[DATA_W-1:3], 3'b000};
                  dmem_wdata <= in_rs2_data << {off, 3'b000};
                  dmem_wstrb <= mask9[7:0];
                  acc_q      <= '{off: off, width: in_write_width,
                                  uns: in_load_unsigned, rd: in_rd};
               end else begin
                  wb_valid  <= 1'b1;
                  wb_reg_we <= (in_wb_select != 2'b11) && (in_rd != 5'd0);
                  wb_rd     <= in_rd;
                  if (in_wb_select == 2'b00)      wb_data <= in_alu_res;
                  else if (in_wb_select == 2'b10) wb_data <= in_pc_plus_4;
               end
            end
            REQ: if (dmem_gnt) begin
               dmem_req <= 1'b0;
               if (dmem_we) begin
                  wb_valid  <= 1'b1;
                  wb_reg_we <= 1'b0;
                  wb_rd     <= acc_q.rd;
                  state     <= IDLE;
               end else begin
                  state <= RESP;
               end
            end
            RESP: if (dmem_rvalid) begin
               wb_valid  <= 1'b1;
               wb_reg_we <= (acc_q.rd != 5'd0);
               wb_rd     <= acc_q.rd;
               wb_data   <= ld_fmt;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the EX/MEM register and the MEM/WB writeback path. It takes the latched EX/MEM fields, performs byte-lane-aligned loads and stores over a req/gnt/rvalid data-memory port, and stalls upstream while an access is outstanding. It formats load data by width and sign, selects the writeback value, and registers the result for writeback.

## Interface
Parameters:
- DATA_W, 64: datapath width; the byte-lane logic requires 64.
- RST_PC4, 0: reserved; no effect.

Ports:
- sys_clk  in  1  clock; all state updates on the rising edge.
- sys_rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  EX/MEM slot holds a valid instruction.
- in_is_write_dmem  in  1  instruction is a store.
- in_wb_select  in  2  writeback source: 00 ALU, 01 memory (load), 10 pc+4, 11 none.
- in_write_width  in  8  byte mask of the access size; legal values 0x01, 0x03, 0x0F, 0xFF.
- in_load_unsigned  in  1  zero-extend load data when 1, sign-extend when 0.
- in_rs2_data  in  64  store data, low-aligned.
- in_alu_res  in  64  effective address, or the ALU result.
- in_pc_plus_4  in  64  link value.
- in_rd  in  5  destination register.
- mem_stall  out  1  combinational; upstream holds EX/MEM while it is 1.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 for a write.
- dmem_addr  out  64  the address with bits [2:0] cleared.
- dmem_wdata  out  64  store data shifted to its byte lane.
- dmem_wstrb  out  8  byte strobes.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  64  read data, doubleword-aligned.
- wb_valid  out  1  registered; writeback slot valid.
- wb_reg_we  out  1  registered; write the register file.
- wb_rd  out  5  registered destination register.
- wb_data  out  64  registered writeback value.
- misalign  out  1  registered one-cycle pulse flagging an illegal access.

## Operation
- access = in_valid & (in_is_write_dmem | in_wb_select==01).
- off = in_alu_res[2:0].
- mask9 = {1'b0, in_write_width} << off.
- Misaligned when mask9[8] is set or when in_write_width is not a legal value. A misaligned access makes no bus request and does not stall. Next edge: wb_valid=1, wb_reg_we=0, misalign=1.
- Store lanes: dmem_wstrb = mask9[7:0] and dmem_wdata = in_rs2_data << (8*off). Both bus fields are latched when REQ is entered.
- Load format:
  - Shift: r = dmem_rdata >> (8*off).
  - Zero-extend: keep the bytes under in_write_width.
  - Sign-extend (in_load_unsigned=0): fill the upper bytes from the top bit of the highest masked byte.
  - Example: a byte load of 0x80 gives 0xFFFF_FFFF_FFFF_FF80.
- Non-access instructions complete in one cycle.
  - wb_data = alu_res when wb_select=00, pc_plus_4 when wb_select=10.
  - wb_reg_we = (wb_select != 11) & (rd != 0).
- FSM:
  - IDLE: on an access that is not misaligned, latch addr, wdata, wstrb, we, rd, width and sign, then go to REQ.
  - REQ: dmem_req=1. On gnt, a store completes (wb_valid=1, wb_reg_we=0) and returns to IDLE; a load goes to RESP.
  - RESP: dmem_req=0. On rvalid, wb_data = the formatted load, wb_reg_we = (rd != 0), wb_valid=1, then return to IDLE.
- mem_stall = (IDLE & access & ~misaligned) | (REQ & ~(we & gnt)) | (RESP & ~rvalid).
- rvalid is ignored outside RESP. It is accepted no earlier than the cycle after gnt.
- in_valid=0 in IDLE produces wb_valid=0 on the next edge; the other wb fields hold.

## Timing
- Reset (synchronous): state=IDLE; wb_valid, wb_reg_we, wb_rd, wb_data, misalign, dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb are all 0. Reset asserted in REQ or RESP abandons the access; dmem_req is 0 from the cycle after that edge.
- Non-access instruction: wb outputs are valid 1 edge after acceptance; no stall.
- Store: the IDLE cycle is followed by REQ. With gnt in the first REQ cycle, wb_valid rises 2 edges after the store is presented, and mem_stall=1 for exactly 1 cycle. Each extra cycle gnt is low adds 1 cycle.
- Load: with gnt in the first REQ cycle and rvalid in the first RESP cycle, wb_valid rises 3 edges after the load is presented, with mem_stall=1 for 2 cycles.
- wb_valid and misalign are single-cycle pulses per instruction. Back-to-back accesses: the next access enters REQ on the edge after wb_valid is set.
- dmem_addr, dmem_we, dmem_wdata and dmem_wstrb are stable from REQ entry until gnt.

## Test plan
- ALU op: wb_select=00, alu_res=0x1234, rd=5 → next edge wb_valid=1, wb_reg_we=1, wb_data=0x1234, mem_stall=0.
- Byte store: width=0x01, addr=0x1003, rs2=0xAB → wstrb=0x08, wdata=0xAB000000, dmem_addr=0x1000. With gnt held low 2 cycles, mem_stall=1 for 3 cycles; wb_reg_we=0.
- Signed word load: width=0x0F, addr=0x2004, rdata=0x8000_0001_xxxx_xxxx, unsigned=0 → wb_data=0xFFFF_FFFF_8000_0001. With unsigned=1 → 0x0000_0000_8000_0001.
- Misaligned: width=0x0F, addr=0x06 → no dmem_req, misalign=1 for one cycle, wb_reg_we=0, no stall.
- Load with rd=0 and rvalid delayed 3 cycles → mem_stall held until rvalid, then wb_valid=1, wb_reg_we=0.
- sys_rst asserted in RESP → next edge all outputs 0, state IDLE. A following ALU op completes normally.
